// File: rtl/wei_sram_writer.sv
// ============================================================================
//  Module      : wei_sram_writer
//  Description : Write-side controller for the weight SRAM. Requests a burst
//                from the off-chip interface, writes each accepted word to
//                consecutive wrapping SRAM addresses, and pulses
//                Rd_prepare_Wei once the whole burst has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wei_sram_writer #(
  parameter int PORT_WIDTH      = 128,
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int SRAM_DEPTH      = 4096,
  parameter int CNT_WIDTH       = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SRAM_config_start,
  input  logic                       wr_start,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_base_addr,
  input  logic [CNT_WIDTH-1:0]       wr_num_words,
  input  logic [1:0]                 State_Rd,
  output logic                       WeiIF_req_val,
  input  logic                       IFWei_req_rdy,
  input  logic                       IFWei_data_val,
  output logic                       WeiIF_data_rdy,
  input  logic [PORT_WIDTH-1:0]      IFWei_data,
  output logic                       WeiData_write_en,
  output logic [SRAM_ADDR_WIDTH-1:0] WeiData_wr_addr,
  output logic [PORT_WIDTH-1:0]      WeiData_wr_data,
  output logic                       Rd_prepare_Wei,
  output logic                       wr_busy
);

  localparam logic [1:0]                 RD_READ   = 2'b11;
  localparam logic [SRAM_ADDR_WIDTH-1:0] LAST_ADDR = SRAM_ADDR_WIDTH'(SRAM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_WRITE = 2'b11,
    ST_DONE  = 2'b10
  } state_t;

  state_t                     state;
  logic [SRAM_ADDR_WIDTH-1:0] ptr;
  logic [CNT_WIDTH-1:0]       remaining;
  logic [SRAM_ADDR_WIDTH-1:0] ptr_next;
  logic                       handshake;

  // Handshake strobes are decoded from state so the interface sees them in
  // the same cycle; an abort masks them so nothing new is accepted.
  assign WeiIF_req_val  = (state == ST_REQ) && !SRAM_config_start;
  assign WeiIF_data_rdy = (state == ST_WRITE) && (State_Rd != RD_READ) && !SRAM_config_start;
  assign handshake      = IFWei_data_val && WeiIF_data_rdy;
  assign ptr_next       = (ptr == LAST_ADDR) ? '0 : ptr + SRAM_ADDR_WIDTH'(1);
  assign wr_busy        = (state != ST_IDLE);

  // Burst FSM, write pointer/counter and registered SRAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      ptr              <= '0;
      remaining        <= '0;
      WeiData_write_en <= 1'b0;
      WeiData_wr_addr  <= '0;
      WeiData_wr_data  <= '0;
      Rd_prepare_Wei   <= 1'b0;
    end else begin
      // Write port: one cycle after each accepted word, address/data held otherwise.
      WeiData_write_en <= handshake;
      Rd_prepare_Wei   <= 1'b0;
      if (handshake) begin
        WeiData_wr_addr <= ptr;
        WeiData_wr_data <= IFWei_data;
        ptr             <= ptr_next;
        remaining       <= remaining - CNT_WIDTH'(1);
      end

      if (SRAM_config_start) begin
        // Abort: drop back to IDLE silently, no completion pulse.
        state     <= ST_IDLE;
        remaining <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (wr_start) begin
              ptr       <= wr_base_addr;
              remaining <= wr_num_words;
              if (wr_num_words == '0) begin
                state          <= ST_DONE;
                Rd_prepare_Wei <= 1'b1;
              end else begin
                state <= ST_REQ;
              end
            end
          end
          ST_REQ: begin
            if (IFWei_req_rdy) state <= ST_WRITE;
          end
          ST_WRITE: begin
            // The completion pulse is raised together with entry to DONE so
            // it lines up with the last SRAM write.
            if (handshake && (remaining == CNT_WIDTH'(1))) begin
              state          <= ST_DONE;
              Rd_prepare_Wei <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wei_sram_writer.sv
// ============================================================================
//  Module      : tb_wei_sram_writer
//  Description : Self-checking bench for wei_sram_writer. Accepted words are
//                pushed to an expected-write queue and popped when the SRAM
//                write port fires.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wei_sram_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         SRAM_config_start;
  logic         wr_start;
  logic [15:0]  wr_base_addr;
  logic [11:0]  wr_num_words;
  logic [1:0]   State_Rd;
  logic         WeiIF_req_val;
  logic         IFWei_req_rdy;
  logic         IFWei_data_val;
  logic         WeiIF_data_rdy;
  logic [127:0] IFWei_data;
  logic         WeiData_write_en;
  logic [15:0]  WeiData_wr_addr;
  logic [127:0] WeiData_wr_data;
  logic         Rd_prepare_Wei;
  logic         wr_busy;

  int checks = 0;
  int errors = 0;

  // Per-burst observations
  int n_writes, w_first, w_last, n_prep, prep_cyc, busy_cnt, busy_first, busy_last;

  logic [143:0] exp_q[$];

  wei_sram_writer #(
    .PORT_WIDTH(128), .SRAM_ADDR_WIDTH(16), .SRAM_DEPTH(4096), .CNT_WIDTH(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .SRAM_config_start(SRAM_config_start),
    .wr_start(wr_start), .wr_base_addr(wr_base_addr), .wr_num_words(wr_num_words),
    .State_Rd(State_Rd), .WeiIF_req_val(WeiIF_req_val), .IFWei_req_rdy(IFWei_req_rdy),
    .IFWei_data_val(IFWei_data_val), .WeiIF_data_rdy(WeiIF_data_rdy), .IFWei_data(IFWei_data),
    .WeiData_write_en(WeiData_write_en), .WeiData_wr_addr(WeiData_wr_addr),
    .WeiData_wr_data(WeiData_wr_data), .Rd_prepare_Wei(Rd_prepare_Wei), .wr_busy(wr_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] word_of(input logic [15:0] b, input int i);
    return {b, 16'(i), 32'hC0DE_0000 ^ 32'(i), ~{b, 16'(i)}, 32'h1234_5678 + 32'(i)};
  endfunction

  function automatic logic [15:0] addr_of(input logic [15:0] b, input int i);
    return 16'((32'(b) + i) % 4096);
  endfunction

  task automatic idle_inputs();
    wr_start = 0; SRAM_config_start = 0; State_Rd = 2'b00;
    IFWei_req_rdy = 0; IFWei_data_val = 0; IFWei_data = '0;
    wr_base_addr = 16'h0; wr_num_words = 12'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [6:0] flags;
    checks++;
    flags = {WeiIF_req_val, WeiIF_data_rdy, WeiData_write_en, Rd_prepare_Wei, wr_busy,
             |WeiData_wr_addr, |WeiData_wr_data};
    if (flags !== 7'b0) begin
      errors++;
      $display("FAIL %s: outputs req/rdy/we/prep/busy/addr!=0/data!=0 = %b, required 0000000", tag, flags);
    end
  endtask

  // Runs one burst starting in the current cycle (called at posedge+1).
  // stall_at: first of 3 cycles with State_Rd=RD_READ (-1 none);
  // abort_after: pulse SRAM_config_start the cycle after this many handshakes (-1 none);
  // restart_at: cycle with a stray wr_start carrying other base/count (-1 none).
  task automatic run_burst(input logic [15:0] base, input int n, input int stall_at,
                           input int abort_after, input int restart_at);
    int  c = 0;
    int  idx = 0;
    bit  aborted = 0, abort_next = 0, done = 0;
    logic [143:0] e;
    n_writes = 0; w_first = -1; w_last = -1; n_prep = 0; prep_cyc = -1;
    busy_cnt = 0; busy_first = -1; busy_last = -1;
    while (!done) begin
      wr_start          = (c == 0) || (c == restart_at);
      wr_base_addr      = (c == 0) ? base : ((c == restart_at) ? 16'h0999 : 16'hBEEF);
      wr_num_words      = (c == 0) ? 12'(n) : ((c == restart_at) ? 12'd7 : 12'hABC);
      SRAM_config_start = abort_next;
      State_Rd          = (stall_at >= 0 && c >= stall_at && c < stall_at + 3) ? 2'b11 : 2'b00;
      IFWei_req_rdy     = 1;
      IFWei_data_val    = (idx < n) && !aborted;
      IFWei_data        = word_of(base, idx);
      @(negedge clk);
      if (WeiData_write_en) begin
        n_writes++;
        if (w_first < 0) w_first = c;
        w_last = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: addr=%h with no pending word", WeiData_wr_addr);
        end else begin
          e = exp_q.pop_front();
          if ({WeiData_wr_addr, WeiData_wr_data} !== e) begin
            errors++;
            $display("FAIL sb_write: addr=%h data=%h, required addr=%h data=%h",
                     WeiData_wr_addr, WeiData_wr_data, e[143:128], e[127:0]);
          end
        end
      end
      if (Rd_prepare_Wei) begin n_prep++; prep_cyc = c; end
      if (wr_busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (State_Rd == 2'b11 || SRAM_config_start) begin
        checks++;
        if (WeiIF_data_rdy !== 1'b0 || WeiIF_req_val !== 1'b0) begin
          errors++;
          $display("FAIL blocked_handshake cyc %0d: data_rdy=%b req_val=%b, required 0 0",
                   c, WeiIF_data_rdy, WeiIF_req_val);
        end
      end
      if (stall_at >= 0 && c > stall_at && c <= stall_at + 3) begin
        checks++;
        if (WeiData_write_en !== 1'b0) begin
          errors++;
          $display("FAIL stall_write cyc %0d: write_en=%b, required 0", c, WeiData_write_en);
        end
      end
      if (abort_next) begin aborted = 1; abort_next = 0; end
      if (IFWei_data_val && WeiIF_data_rdy) begin
        exp_q.push_back({addr_of(base, idx), word_of(base, idx)});
        idx++;
        if (idx == abort_after) abort_next = 1;
      end
      if (c > 0 && !wr_busy) done = 1;
      if (c >= 300) begin
        checks++; errors++;
        $display("FAIL burst_timeout: still busy after %0d cycles, required idle", c);
        done = 1;
      end
      @(posedge clk); #1; c++;
    end
    idle_inputs();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d accepted words never written, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic expect_int(input string tag, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", tag, act, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    #12;
    check_reset_outputs("reset_values");
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_basic();
    run_burst(16'h0010, 4, -1, -1, -1);
    expect_int("basic_writes", n_writes, 4);
    expect_int("basic_first_write", w_first, 3);
    expect_int("basic_last_write", w_last, 6);
    expect_int("basic_prep_count", n_prep, 1);
    expect_int("basic_prep_cycle", prep_cyc, 6);
    expect_int("basic_busy_first", busy_first, 1);
    expect_int("basic_busy_last", busy_last, 6);
    expect_int("basic_busy_count", busy_cnt, 6);
  endtask

  task automatic test_wrap();
    run_burst(16'h0FFE, 4, -1, -1, -1);
    expect_int("wrap_writes", n_writes, 4);
    expect_int("wrap_prep_cycle", prep_cyc, 6);
  endtask

  task automatic test_stall();
    run_burst(16'h0200, 6, 3, -1, -1);
    expect_int("stall_writes", n_writes, 6);
    expect_int("stall_prep_count", n_prep, 1);
    expect_int("stall_prep_cycle", prep_cyc, 11);
  endtask

  task automatic test_abort();
    run_burst(16'h0300, 8, -1, 2, -1);
    expect_int("abort_writes", n_writes, 2);
    expect_int("abort_last_write", w_last, 4);
    expect_int("abort_prep_count", n_prep, 0);
    run_burst(16'h0100, 2, -1, -1, -1);
    expect_int("after_abort_writes", n_writes, 2);
    expect_int("after_abort_prep_cycle", prep_cyc, 4);
  endtask

  task automatic test_zero_and_ignored();
    run_burst(16'h0040, 0, -1, -1, -1);
    expect_int("zero_writes", n_writes, 0);
    expect_int("zero_prep_cycle", prep_cyc, 1);
    expect_int("zero_busy_count", busy_cnt, 1);
    run_burst(16'h0500, 3, -1, -1, 1);
    expect_int("ignored_start_writes", n_writes, 3);
    expect_int("ignored_start_prep_cycle", prep_cyc, 5);
  endtask

  task automatic test_async_reset();
    wr_start = 1; wr_base_addr = 16'h0700; wr_num_words = 12'd5;
    IFWei_req_rdy = 1; IFWei_data_val = 1; IFWei_data = word_of(16'h0700, 0);
    @(posedge clk); #1; wr_start = 0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (!(wr_busy && WeiData_write_en)) begin
      errors++;
      $display("FAIL async_precondition: busy=%b write_en=%b, required 1 1", wr_busy, WeiData_write_en);
    end
    #2 rst_n = 0;
    #1 check_reset_outputs("async_reset_immediate");
    idle_inputs();
    @(posedge clk); #1;
    check_reset_outputs("async_reset_held");
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_abort();
    test_zero_and_ignored();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wei_sram_writer.md
# wei_sram_writer

Write-side controller for the weight SRAM in the global buffer. It requests a weight burst from the off-chip interface and accepts PORT_WIDTH-bit words over a val/rdy handshake. Each accepted word is written into the weight SRAM at consecutive, wrapping addresses. When the burst is fully written, it pulses Rd_prepare_Wei so the weight read controller can start serving PE instruction requests. It stalls writes while the read controller is in its RD_READ state.

## Interface
- PORT_WIDTH, 128, SRAM word / interface data width
- SRAM_ADDR_WIDTH, 16, SRAM address width
- SRAM_DEPTH, 4096, number of SRAM words; addresses wrap at SRAM_DEPTH-1
- CNT_WIDTH, 12, width of burst word count

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- SRAM_config_start  in  1  global abort/restart; forces IDLE
- wr_start  in  1  start a burst; sampled only in IDLE
- wr_base_addr  in  SRAM_ADDR_WIDTH  first write address; latched with wr_start
- wr_num_words  in  CNT_WIDTH  burst length in words; latched with wr_start
- State_Rd  in  2  read controller state; 2'b11 = RD_READ
- WeiIF_req_val  out  1  burst request to interface
- IFWei_req_rdy  in  1  interface accepts request
- IFWei_data_val  in  1  data word valid
- WeiIF_data_rdy  out  1  writer ready for data word
- IFWei_data  in  PORT_WIDTH  data word
- WeiData_write_en  out  1  SRAM write enable (registered)
- WeiData_wr_addr  out  SRAM_ADDR_WIDTH  SRAM write address (registered)
- WeiData_wr_data  out  PORT_WIDTH  SRAM write data (registered)
- Rd_prepare_Wei  out  1  one-cycle pulse: burst complete
- wr_busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE=2'b00, REQ=2'b01, WRITE=2'b11, DONE=2'b10.
- IDLE:
  - wr_start=1 and SRAM_config_start=0 latches the base address into the write pointer and wr_num_words into the remaining counter.
  - The FSM then goes to REQ, or to DONE directly if wr_num_words==0.
- REQ: WeiIF_req_val=1. When IFWei_req_rdy=1 in the same cycle, go to WRITE.
- WRITE:
  - WeiIF_data_rdy = (State_Rd != 2'b11).
  - A handshake (IFWei_data_val & WeiIF_data_rdy) registers write_en=1, the current pointer and the data into the SRAM outputs.
  - On a handshake the pointer increments, and the remaining counter decrements.
  - Handshake with remaining==1: go to DONE.
- Pointer wrap: when the pointer equals SRAM_DEPTH-1, the next value is 0. The pointer is SRAM_ADDR_WIDTH bits.
- DONE: Rd_prepare_Wei=1 for exactly this cycle, then go to IDLE.
- WeiIF_req_val and WeiIF_data_rdy are 0 outside REQ and WRITE respectively.
- WeiData_write_en=1 only in the cycle after a handshake. Address and data hold their last value otherwise.
- SRAM_config_start=1 in any state: next state is IDLE, with no Rd_prepare_Wei pulse and the counter cleared.
  - A write already registered from the previous cycle's handshake still appears on the outputs.
  - No new handshake is accepted in a cycle where SRAM_config_start=1: WeiIF_data_rdy and WeiIF_req_val are forced 0.
- wr_start outside IDLE is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - WeiIF_req_val, WeiIF_data_rdy, WeiData_write_en, Rd_prepare_Wei and wr_busy are 0.
  - WeiData_wr_addr and WeiData_wr_data are 0, and the pointer and counter are 0.
- Handshake to SRAM write: 1 cycle. Throughput: 1 word/cycle when there is no stall.
- Burst sequence with immediate req_rdy and back-to-back data, N words:
  - Cycle 0: wr_start.
  - Cycle 1: REQ.
  - Cycles 2..N+1: data handshakes.
  - Cycles 3..N+2: SRAM writes.
  - Cycle N+2: DONE, with Rd_prepare_Wei=1.
  - Cycle N+3: IDLE. The last write and Rd_prepare_Wei are coincident.
- N=0 sequence: cycle 0 wr_start, cycle 1 DONE pulse, cycle 2 IDLE.
- A State_Rd transition to 2'b11 drops WeiIF_data_rdy in the same cycle (combinational). Data stays pending at the interface.
- Outputs are registered, except WeiIF_req_val and WeiIF_data_rdy, which are decoded from state and inputs.

## Test plan
- Basic burst:
  - Stimulus: base=0x0010, N=4, req_rdy and val held 1, data D0..D3.
  - Response: writes at 0x0010..0x0013 on cycles 3..6, Rd_prepare_Wei high only in cycle 6, wr_busy high in cycles 1..6.
- Wrap:
  - Stimulus: SRAM_DEPTH=4096, base=0x0FFE, N=4.
  - Response: write addresses 0x0FFE, 0x0FFF, 0x0000, 0x0001.
- Read stall:
  - Stimulus: State_Rd=2'b11 for 3 cycles mid-burst, with IFWei_data_val=1.
  - Response: WeiIF_data_rdy=0 and no write_en for those cycles, the burst resumes afterwards, and all words are written exactly once and in order.
- Abort:
  - Stimulus: SRAM_config_start pulse after 2 of 8 words have handshaken.
  - Response: the 2nd word's write still completes, then IDLE with no Rd_prepare_Wei. A new wr_start with base=0x0100, N=2 then works normally.
- Zero length and ignored start:
  - Stimulus: wr_num_words=0, then a second wr_start asserted during the REQ state of another burst.
  - Response: the N=0 burst gives a DONE pulse 1 cycle after wr_start with no writes. The second wr_start has no effect on the base address or count.
- Async reset:
  - Stimulus: rst_n low mid-WRITE.
  - Response: all outputs return to their reset values immediately, without waiting for a clock edge.
